block_mult_sequencer_4x4: RTL and testbench
===========================================

// Module: block_mult_sequencer_4x4
// PURPOSE
// - Start/done initiator for base_matrix_multiplier (the 2x2 integer block engine): computes C = A*B for 4x4 integer matrices.
// - Splits A and B into 2x2 blocks and issues 8 block products through the engine's start/done interface.
// - Accumulates C_IJ = A_I0*B_0J + A_I1*B_1J and returns the full 4x4 result with a one-cycle done pulse.
// - Sits between the top-level matrix interface and the base engine.
// PARAMETERS
// - w        8     element width in bits (A, B, C and engine ports)
// - TIMEOUT  1024  max cycles to wait for bm_done per block product (>=1)
// PORTS
// - clk       in   1      clock; all logic on posedge
// - rst       in   1      reset, synchronous, active-low
// - start     in   1      request; sampled only in IDLE
// - i_a       in   16*w   A; element (r,c) at bits [(4*r+c)*w +: w]
// - i_b       in   16*w   B; same packing as i_a
// - o_c       out  16*w   C; same packing; valid while done=1 and held until next start
// - done      out  1      one-cycle completion pulse
// - err       out  1      high with done when a product timed out
// - busy      out  1      high in every state except IDLE
// - bm_start  out  1      one-cycle start pulse to the engine
// - bm_a11..bm_a22, bm_b11..bm_b22  out  w each  engine operands (current A/B block)
// - bm_c11..bm_c22  in  w each  engine results; sampled in the cycle bm_done=1
// - bm_done   in   1      engine completion pulse
// BEHAVIOUR
// - Reset (rst=0 at posedge): state IDLE; o_c, done, err, busy, bm_start and all bm_a*/bm_b* = 0; accumulators and counters cleared.
// - Reset mid-operation: abort immediately; no done pulse; in-flight bm_done is ignored after reset.
// - States: IDLE, ISSUE, WAIT, FINISH (encoded 2 bits).
// - IDLE: on start=1, latch i_a/i_b, clear product index p, go to ISSUE. Other cycles: hold o_c.
// - ISSUE: bm_start=1 for exactly this cycle; bm_a*/bm_b* drive blocks A_IK and B_KJ. Go to WAIT.
// - Operand order: p=0..7 maps to (I,J,K) = {p[2],p[1],p[0]}. K varies fastest.
// - Operands: stable from ISSUE until bm_done is accepted. The engine latches on its start cycle.
// - WAIT: bm_start=0. On bm_done=1:
//   - K=0: load the C_IJ accumulator with bm_c*.
//   - K=1: add bm_c* into the C_IJ accumulator.
//   - Then go to ISSUE with p+1, or go to FINISH if p=7.
// - bm_done seen outside WAIT is ignored. bm_done is never honoured in the ISSUE cycle.
// - Next bm_start is never issued earlier than the cycle after the accepted bm_done.
// - Arithmetic: element-wise w-bit addition, modulo 2^w; no saturation, no overflow flag.
// - Timeout: WAIT counter starts at 0 on entry. If it reaches TIMEOUT with no bm_done, go to FINISH with err=1 and o_c forced to 0.
// - FINISH: o_c <= accumulators (or 0 on err); done=1 for this cycle only; err valid this cycle only; next state IDLE.
// - start while busy=1: ignored. start held high: a new run begins on the cycle after the return to IDLE.
// - Latency: start sampled at cycle T; engine responds D cycles after each bm_start. Then done=1 at T+9+8*D.
// STRUCTURE
// - Shared package: state encoding (IDLE/ISSUE/WAIT/FINISH), p-field bit positions (I,J,K), element pack/unpack index function.
// - One sub-module: block_operand_mux (combinational; selects the 2x2 A_IK / B_KJ blocks from the latched matrices by p).
// - Accumulators, FSM and timeout counter stay in this module.
// TESTING (bench uses a stub engine: bm_done D cycles after bm_start, bm_c = exact 2x2 product mod 2^w)
// - Identity: A=I, B elements 1..16 row-major, D=3 -> o_c==B, done at T+33, err=0.
// - Latency/handshake: D=5 -> exactly 8 bm_start pulses, each 1 cycle, each after the prior bm_done; done at T+49.
// - Wrap: w=8, all A,B elements 0x0F -> every o_c element 0x84 (4*225 mod 256).
// - Timeout: TIMEOUT=16, stub never asserts bm_done -> done=1 and err=1 at T+18, o_c==0; busy low on the next cycle.
// - Reset mid-op: rst=0 during 3rd WAIT -> next cycle all outputs 0, no done; a fresh start then yields the correct result.
// - Busy/stray: start pulse and stray bm_done during ISSUE -> ignored; result unchanged vs. the clean run.

Source files
------------

// File: rtl/block_mult_sequencer_4x4_pkg.sv
// Shared definitions for the 4x4 block matrix multiply sequencer.
//   - FSM state encoding (IDLE/ISSUE/WAIT/FINISH)
//   - bit positions of the I/J/K fields inside the 3-bit product index p
//   - element index helper for the row-major 4x4 packing
package block_mult_sequencer_4x4_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // p = {I, J, K}; K varies fastest so both partial products of a C block
  // are issued back to back.
  localparam int P_I = 2;
  localparam int P_J = 1;
  localparam int P_K = 0;

  // Element (r,c) of a packed 4x4 matrix lives at [elem_idx(r,c)*w +: w].
  function automatic int elem_idx(input int r, input int c);
    return 4 * r + c;
  endfunction

endpackage

// File: rtl/block_operand_mux.sv
// Combinational selector of the 2x2 engine operands.
//   a_i, b_i : latched 4x4 matrices (row-major packing)
//   p_i      : product index {I,J,K}
//   a*_o     : block A_IK, b*_o : block B_KJ (suffix = row,col within block)
module block_operand_mux
  import block_mult_sequencer_4x4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [16*W-1:0] a_i,
  input  logic [16*W-1:0] b_i,
  input  logic [2:0]      p_i,
  output logic [W-1:0]    a11_o,
  output logic [W-1:0]    a12_o,
  output logic [W-1:0]    a21_o,
  output logic [W-1:0]    a22_o,
  output logic [W-1:0]    b11_o,
  output logic [W-1:0]    b12_o,
  output logic [W-1:0]    b21_o,
  output logic [W-1:0]    b22_o
);

  logic [3:0][W-1:0] a_blk;
  logic [3:0][W-1:0] b_blk;

  always_comb begin
    a_blk = '0;
    b_blk = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        a_blk[2*r+c] = a_i[elem_idx(2*int'(p_i[P_I]) + r, 2*int'(p_i[P_K]) + c)*W +: W];
        b_blk[2*r+c] = b_i[elem_idx(2*int'(p_i[P_K]) + r, 2*int'(p_i[P_J]) + c)*W +: W];
      end
    end
  end

  assign a11_o = a_blk[0];
  assign a12_o = a_blk[1];
  assign a21_o = a_blk[2];
  assign a22_o = a_blk[3];
  assign b11_o = b_blk[0];
  assign b12_o = b_blk[1];
  assign b21_o = b_blk[2];
  assign b22_o = b_blk[3];

endmodule

// File: rtl/block_mult_sequencer_4x4.sv
// 4x4 matrix multiplier built on a 2x2 start/done block engine.
// Issues the 8 block products C_IJ += A_IK*B_KJ, accumulates modulo 2^w and
// presents C on o_c with a one-cycle done pulse (err=1 on engine timeout).
//   clk, rst (sync, active-low), start, i_a, i_b  : request side
//   o_c, done, err, busy                          : result side
//   bm_start, bm_a*, bm_b*, bm_c*, bm_done        : engine side
module block_mult_sequencer_4x4
  import block_mult_sequencer_4x4_pkg::*;
#(
  parameter int w       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [16*w-1:0] i_a,
  input  logic [16*w-1:0] i_b,
  output logic [16*w-1:0] o_c,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          bm_start,
  output logic [w-1:0]  bm_a11,
  output logic [w-1:0]  bm_a12,
  output logic [w-1:0]  bm_a21,
  output logic [w-1:0]  bm_a22,
  output logic [w-1:0]  bm_b11,
  output logic [w-1:0]  bm_b12,
  output logic [w-1:0]  bm_b21,
  output logic [w-1:0]  bm_b22,
  input  logic [w-1:0]  bm_c11,
  input  logic [w-1:0]  bm_c12,
  input  logic [w-1:0]  bm_c21,
  input  logic [w-1:0]  bm_c22,
  input  logic          bm_done
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Leaving WAIT on this count means TIMEOUT WAIT cycles elapsed.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [2:0]      p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [16*w-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, oc_q, oc_d;
  logic            done_q, done_d, err_q, err_d;
  logic [3:0][w-1:0] bmc;

  assign bmc = {bm_c22, bm_c21, bm_c12, bm_c11};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    oc_d    = oc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = i_a;
          b_d     = i_b;
          p_d     = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bm_done) begin
          // K=0 loads the C_IJ block, K=1 adds the second partial product.
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
              acc_d[elem_idx(2*int'(p_q[P_I]) + r, 2*int'(p_q[P_J]) + c)*w +: w] =
                (p_q[P_K] ? acc_q[elem_idx(2*int'(p_q[P_I]) + r, 2*int'(p_q[P_J]) + c)*w +: w]
                          : '0) + bmc[2*r+c];
            end
          end
          if (p_q == 3'd7) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            oc_d    = acc_d;
          end else begin
            p_d     = p_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          err_d   = 1'b1;
          oc_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // done/err/o_c are registered on the transition into FINISH so that they
  // are valid exactly during the FINISH cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      oc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      oc_q    <= oc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_c      = oc_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign bm_start = (state_q == ST_ISSUE);

  block_operand_mux #(.W(w)) u_mux (
    .a_i   (a_q),
    .b_i   (b_q),
    .p_i   (p_q),
    .a11_o (bm_a11),
    .a12_o (bm_a12),
    .a21_o (bm_a21),
    .a22_o (bm_a22),
    .b11_o (bm_b11),
    .b12_o (bm_b12),
    .b21_o (bm_b21),
    .b22_o (bm_b22)
  );

endmodule

// File: tb/tb_block_mult_sequencer_4x4.sv
module tb_block_mult_sequencer_4x4;

  localparam int W   = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst, start, done, err, busy, bm_start, bm_done;
  logic [16*W-1:0] i_a, i_b, o_c;
  logic [W-1:0] bm_a11, bm_a12, bm_a21, bm_a22, bm_b11, bm_b12, bm_b21, bm_b22;
  logic [W-1:0] bm_c11, bm_c12, bm_c21, bm_c22;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  block_mult_sequencer_4x4 #(.w(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .i_a(i_a), .i_b(i_b), .o_c(o_c),
    .done(done), .err(err), .busy(busy), .bm_start(bm_start),
    .bm_a11(bm_a11), .bm_a12(bm_a12), .bm_a21(bm_a21), .bm_a22(bm_a22),
    .bm_b11(bm_b11), .bm_b12(bm_b12), .bm_b21(bm_b21), .bm_b22(bm_b22),
    .bm_c11(bm_c11), .bm_c12(bm_c12), .bm_c21(bm_c21), .bm_c22(bm_c22),
    .bm_done(bm_done)
  );

  // ---------------- stub engine ----------------
  int s_d = 1;
  bit s_never = 1'b0;
  bit s_stray = 1'b0;
  int s_cnt = 0;
  int nstart = 0;
  int hs_err = 0;
  bit prev_st = 1'b0;
  logic [W-1:0] sa [2][2];
  logic [W-1:0] sb [2][2];

  function automatic logic [W-1:0] pr(input logic [W-1:0] x0, x1, y0, y1);
    return x0 * y0 + x1 * y1;
  endfunction

  initial begin
    bm_done = 1'b0;
    bm_c11 = '0; bm_c12 = '0; bm_c21 = '0; bm_c22 = '0;
  end

  always @(negedge clk) begin
    bm_done = 1'b0;
    if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        bm_done = 1'b1;
        bm_c11 = pr(sa[0][0], sa[0][1], sb[0][0], sb[1][0]);
        bm_c12 = pr(sa[0][0], sa[0][1], sb[0][1], sb[1][1]);
        bm_c21 = pr(sa[1][0], sa[1][1], sb[0][0], sb[1][0]);
        bm_c22 = pr(sa[1][0], sa[1][1], sb[0][1], sb[1][1]);
      end
    end
    if (bm_start) begin
      nstart++;
      if (prev_st || s_cnt != 0) hs_err++;
      sa[0][0] = bm_a11; sa[0][1] = bm_a12; sa[1][0] = bm_a21; sa[1][1] = bm_a22;
      sb[0][0] = bm_b11; sb[0][1] = bm_b12; sb[1][0] = bm_b21; sb[1][1] = bm_b22;
      if (!s_never) s_cnt = s_d;
      if (s_stray) begin
        bm_done = 1'b1;
        bm_c11 = W'($urandom); bm_c12 = W'($urandom);
        bm_c21 = W'($urandom); bm_c22 = W'($urandom);
      end
    end
    prev_st = bm_start;
  end

  // ---------------- reference model ----------------
  function automatic logic [16*W-1:0] matmul(input logic [16*W-1:0] a, b);
    logic [16*W-1:0] r;
    logic [W-1:0] s;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s = s + a[(4*i+k)*W +: W] * b[(4*k+j)*W +: W];
        r[(4*i+j)*W +: W] = s;
      end
    return r;
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int run_t = 0, exp_done_cyc = 0, exp_ns = 0, n0 = 0;
  bit exp_err = 1'b0;
  logic [16*W-1:0] exp_c = '0, held_c = '0;

  task automatic chk(input string nm, input logic [16*W-1:0] act, input logic [16*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_cycle();
    bit exp_done, exp_busy;
    if (!chk_en) return;
    exp_done = (cyc == exp_done_cyc);
    exp_busy = (cyc > run_t) && (cyc <= exp_done_cyc);
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
    if (exp_done) begin
      chk("err", err, exp_err);
      chk("o_c", o_c, exp_c);
      chk("bm_start_count", nstart - n0, exp_ns);
      chk("handshake", hs_err, 0);
      held_c = exp_c;
    end else begin
      chk("err_idle", err, 1'b0);
      chk("o_c_hold", o_c, held_c);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic run(input logic [16*W-1:0] a, b, input int d, input bit never,
                     input bit stray, input int lat);
    s_d = d; s_never = never; s_stray = stray;
    i_a = a; i_b = b;
    exp_err = never;
    exp_c = never ? '0 : matmul(a, b);
    exp_ns = never ? 1 : 8;
    n0 = nstart;
    run_t = cyc;
    exp_done_cyc = cyc + lat;
    start = 1'b1;
    step();
    start = 1'b0;
    i_a = {$urandom, $urandom, $urandom, $urandom};
    i_b = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < lat + 3; k++) begin
      step();
      if (stray && k == 4) start = 1'b1;
      if (stray && k == 5) start = 1'b0;
    end
    s_never = 1'b0; s_stray = 1'b0;
  endtask

  logic [16*W-1:0] ident, seq, allf, c84, ones, ra, rb, hm;

  initial begin
    rst = 1'b0; start = 1'b0; i_a = '0; i_b = '0;
    ident = '0; seq = '0; ones = '0;
    for (int i = 0; i < 4; i++) ident[(5*i)*W +: W] = 8'd1;
    for (int k = 0; k < 16; k++) begin
      seq[k*W +: W] = W'(k + 1);
      ones[k*W +: W] = 8'd1;
    end
    allf = {16{8'h0F}};
    c84  = {16{8'h84}};

    repeat (3) step();
    chk("rst_o_c", o_c, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bm_start", bm_start, 1'b0);
    chk("rst_operands", {bm_a11, bm_a12, bm_a21, bm_a22, bm_b11, bm_b12, bm_b21, bm_b22}, '0);
    rst = 1'b1;

    // pin the model with hand-computed values
    chk("model_identity", matmul(ident, seq), seq);
    chk("model_wrap", matmul(allf, allf), c84);
    hm = matmul(ones, seq);
    chk("model_colsum03", hm[3*W +: W], 8'd40);
    chk("model_colsum30", hm[12*W +: W], 8'd28);

    run_t = cyc; exp_done_cyc = cyc; chk_en = 1'b1;
    step();

    run(ident, seq, 3, 0, 0, 33);
    chk("identity_result_literal", held_c, seq);
    run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, 0, 0, 49);
    run(allf, allf, 2, 0, 0, 25);
    chk("wrap_result_literal", held_c, c84);
    for (int n = 0; n < 5; n++) begin
      int d;
      d = $urandom_range(1, 4);
      run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, d, 0, 0, 9 + 8*d);
    end
    // engine never answers: timeout after TMO WAIT cycles
    run(seq, seq, 1, 1, 0, 18);

    // stray start/bm_done must not alter a result
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run(ra, rb, 2, 0, 0, 25);
    run(ra, rb, 2, 0, 1, 25);

    // reset during the third WAIT
    chk_en = 1'b0;
    s_d = 4;
    i_a = ra; i_b = seq;
    n0 = nstart;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && (nstart - n0) < 3; k++) step();
    chk("third_issue_seen", (nstart - n0) >= 3, 1'b1);
    step();
    chk("in_wait_before_reset", {busy, bm_start}, 2'b10);
    rst = 1'b0;
    step();
    chk("midrst_o_c", o_c, '0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_bm_start", bm_start, 1'b0);
    chk("midrst_operands", {bm_a11, bm_a12, bm_a21, bm_a22, bm_b11, bm_b12, bm_b21, bm_b22}, '0);
    rst = 1'b1;
    held_c = '0;
    run_t = cyc; exp_done_cyc = cyc; chk_en = 1'b1;
    repeat (12) step();
    run(ra, seq, 4, 0, 0, 41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
